c_tile_buffer: RTL and testbench

Parametrised result-tile store for the Strassen datapath: holds a DIM×DIM output tile of WIDTH-bit entries, accepts two write ports per cycle with overwrite or accumulate mode, and exposes the whole tile both as a flat parallel bus and as a valid/ready stream. It sits between the quadrant adders and the output/recursion controller. It is the generalised successor of the fixed four-entry C store: DIM, WIDTH, accumulation, clearing and streamed readout are new.

---
 rtl/strassen_pkg.sv | 23 ++
 rtl/c_entry_update.sv | 54 +++++
 rtl/c_tile_buffer.sv | 138 +++++++++++++
 tb/tb_c_tile_buffer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/strassen_pkg.sv
// +----------------------------------------------------------------------+
// | strassen_pkg : shared types and helpers for the Strassen datapath     |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

package strassen_pkg;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } state_t;

  localparam logic MODE_OVR = 1'b0;
  localparam logic MODE_ACC = 1'b1;

  function automatic int calc_aw(input int dim);
    return (dim * dim > 1) ? $clog2(dim * dim) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/c_entry_update.sv
// +----------------------------------------------------------------------+
// | c_entry_update : next value of one tile entry from two write ports    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module c_entry_update
  import strassen_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] cur,
  input  logic             hit1,
  input  logic             hit2,
  input  logic             mode1,
  input  logic             mode2,
  input  logic [WIDTH-1:0] din1,
  input  logic [WIDTH-1:0] din2,
  output logic [WIDTH-1:0] new_val,
  output logic             carry
);

  logic [WIDTH:0]   w_sum1;
  logic [WIDTH:0]   w_sum2;
  logic [WIDTH-1:0] w_mid;

  // Port 2 operates on the result of port 1 when both hit this entry.
  always_comb begin
    w_sum1  = {1'b0, cur} + {1'b0, din1};
    w_mid   = cur;
    carry   = 1'b0;
    if (hit1) begin
      if (mode1 == MODE_OVR) begin
        w_mid = din1;
      end else begin
        w_mid = w_sum1[WIDTH-1:0];
        carry = w_sum1[WIDTH];
      end
    end
    w_sum2  = {1'b0, w_mid} + {1'b0, din2};
    new_val = w_mid;
    if (hit2) begin
      if (mode2 == MODE_ACC) begin
        new_val = w_sum2[WIDTH-1:0];
        carry   = carry | w_sum2[WIDTH];
      end else begin
        new_val = din2;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/c_tile_buffer.sv
// +----------------------------------------------------------------------+
// | c_tile_buffer : DIMxDIM result tile, dual write port, streamed readout|
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module c_tile_buffer
  import strassen_pkg::*;
#(
  parameter  int WIDTH = 32,
  parameter  int DIM   = 2,
  localparam int N     = DIM * DIM,
  localparam int AW    = calc_aw(DIM)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               wr_valid1,
  input  logic               wr_valid2,
  input  logic [AW-1:0]      wr_addr1,
  input  logic [AW-1:0]      wr_addr2,
  input  logic               wr_acc1,
  input  logic               wr_acc2,
  input  logic [WIDTH-1:0]   din1,
  input  logic [WIDTH-1:0]   din2,
  output logic               wr_ready,
  input  logic               start,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic               out_last,
  output logic               busy,
  output logic               ovf,
  output logic [WIDTH*N-1:0] tile_flat
);

  localparam logic [AW-1:0] LAST_IDX = AW'(N - 1);

  logic [WIDTH-1:0] r_mem [N];
  logic [WIDTH-1:0] w_new [N];
  logic [N-1:0]     w_carry;
  state_t           r_state;
  logic [AW-1:0]    r_idx;
  logic             w_en1;
  logic             w_en2;

  assign w_en1 = wr_valid1 & wr_ready;
  assign w_en2 = wr_valid2 & wr_ready;

  // Out-of-range addresses never match any entry index, so they drop naturally.
  generate
    for (genvar i = 0; i < N; i++) begin : g_entry
      c_entry_update #(.WIDTH(WIDTH)) u_upd (
        .cur     (r_mem[i]),
        .hit1    (w_en1 && (wr_addr1 == AW'(i))),
        .hit2    (w_en2 && (wr_addr2 == AW'(i))),
        .mode1   (wr_acc1),
        .mode2   (wr_acc2),
        .din1    (din1),
        .din2    (din2),
        .new_val (w_new[i]),
        .carry   (w_carry[i])
      );
      assign tile_flat[i*WIDTH +: WIDTH] = r_mem[i];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < N; i++) r_mem[i] <= '0;
      ovf <= 1'b0;
    end else if (clear) begin
      for (int i = 0; i < N; i++) r_mem[i] <= '0;
      ovf <= 1'b0;
    end else begin
      for (int i = 0; i < N; i++) r_mem[i] <= w_new[i];
      if (|w_carry) ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      wr_ready  <= 1'b1;
    end else if (clear) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      wr_ready  <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state   <= ST_STREAM;
            r_idx     <= '0;
            out_valid <= 1'b1;
            out_last  <= (LAST_IDX == '0);
            busy      <= 1'b1;
            wr_ready  <= 1'b0;
          end
        end
        ST_STREAM: begin
          if (out_ready) begin
            if (out_last) begin
              r_state   <= ST_IDLE;
              r_idx     <= '0;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
              busy      <= 1'b0;
              wr_ready  <= 1'b1;
            end else begin
              r_idx    <= r_idx + AW'(1);
              out_last <= ((r_idx + AW'(1)) == LAST_IDX);
            end
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          out_valid <= 1'b0;
          busy      <= 1'b0;
          wr_ready  <= 1'b1;
        end
      endcase
    end
  end

  // Writes are blocked while streaming, so the entry under idx is stable across stalls.
  assign out_data = out_valid ? r_mem[r_idx] : '0;

endmodule

`default_nettype wire

// File: tb/tb_c_tile_buffer.sv
// +----------------------------------------------------------------------+
// | tb_c_tile_buffer : directed scoreboard bench for c_tile_buffer        |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_c_tile_buffer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic         a_clear, a_wv1, a_wv2, a_acc1, a_acc2, a_start, a_ordy;
  logic [1:0]   a_ad1, a_ad2;
  logic [31:0]  a_d1, a_d2, a_odata;
  logic         a_wr_ready, a_ovalid, a_olast, a_busy, a_ovf;
  logic [127:0] a_flat;

  logic         b_clear, b_wv1, b_wv2, b_acc1, b_acc2, b_start, b_ordy;
  logic [3:0]   b_ad1, b_ad2;
  logic [15:0]  b_d1, b_d2, b_odata;
  logic         b_wr_ready, b_ovalid, b_olast, b_busy, b_ovf;
  logic [143:0] b_flat;

  int tests = 0;
  int fails = 0;
  logic [31:0] sb[$];

  c_tile_buffer #(.WIDTH(32), .DIM(2)) u_a (
    .clk(clk), .reset(reset), .clear(a_clear),
    .wr_valid1(a_wv1), .wr_valid2(a_wv2), .wr_addr1(a_ad1), .wr_addr2(a_ad2),
    .wr_acc1(a_acc1), .wr_acc2(a_acc2), .din1(a_d1), .din2(a_d2),
    .wr_ready(a_wr_ready), .start(a_start), .out_valid(a_ovalid), .out_ready(a_ordy),
    .out_data(a_odata), .out_last(a_olast), .busy(a_busy), .ovf(a_ovf), .tile_flat(a_flat)
  );

  c_tile_buffer #(.WIDTH(16), .DIM(3)) u_b (
    .clk(clk), .reset(reset), .clear(b_clear),
    .wr_valid1(b_wv1), .wr_valid2(b_wv2), .wr_addr1(b_ad1), .wr_addr2(b_ad2),
    .wr_acc1(b_acc1), .wr_acc2(b_acc2), .din1(b_d1), .din2(b_d2),
    .wr_ready(b_wr_ready), .start(b_start), .out_valid(b_ovalid), .out_ready(b_ordy),
    .out_data(b_odata), .out_last(b_olast), .busy(b_busy), .ovf(b_ovf), .tile_flat(b_flat)
  );

  task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One write cycle on DUT A; returns at the negedge after the write edge.
  task automatic a_write(input bit v1, input int ad1, input logic [31:0] d1, input bit acc1,
                         input bit v2, input int ad2, input logic [31:0] d2, input bit acc2);
    a_wv1 = v1; a_ad1 = 2'(ad1); a_d1 = d1; a_acc1 = acc1;
    a_wv2 = v2; a_ad2 = 2'(ad2); a_d2 = d2; a_acc2 = acc2;
    @(negedge clk);
    a_wv1 = 1'b0; a_wv2 = 1'b0;
  endtask

  task automatic b_write(input bit v1, input int ad1, input logic [15:0] d1,
                         input bit v2, input int ad2, input logic [15:0] d2);
    b_wv1 = v1; b_ad1 = 4'(ad1); b_d1 = d1; b_acc1 = 1'b0;
    b_wv2 = v2; b_ad2 = 4'(ad2); b_d2 = d2; b_acc2 = 1'b0;
    @(negedge clk);
    b_wv1 = 1'b0; b_wv2 = 1'b0;
  endtask

  // Streams DUT A with a ready pattern (bit k = out_ready in cycle k); optional held write.
  task automatic a_stream(input logic [15:0] pat, input int plen, input bit wr_busy);
    int k = 0;
    logic [31:0] e;
    for (int i = 0; i < 4; i++) sb.push_back(32'((i + 1) * 10));
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    chk("a_first_valid", a_ovalid, 1);
    while (sb.size() > 0 && k < plen + 8) begin
      a_ordy = (k < plen) ? pat[k] : 1'b1;
      a_wv1  = wr_busy && (k < 2);
      a_ad1  = 2'd0; a_d1 = 32'd99; a_acc1 = 1'b0;
      chk("a_wr_ready_busy", a_wr_ready, 0);
      chk("a_busy_stream", a_busy, 1);
      if (a_ovalid) begin
        chk("a_out_data", a_odata, sb[0]);
        chk("a_out_last", a_olast, (sb.size() == 1));
        if (a_ordy) e = sb.pop_front();
      end else begin
        chk("a_valid_drop", a_ovalid, 1);
      end
      @(negedge clk);
      k++;
    end
    a_wv1 = 1'b0;
    a_ordy = 1'b0;
    chk("a_stream_drained", sb.size(), 0);
    chk("a_busy_after", a_busy, 0);
    chk("a_valid_after", a_ovalid, 0);
    chk("a_wr_ready_after", a_wr_ready, 1);
  endtask

  initial begin
    logic [143:0] bexp;
    int cyc;
    reset = 1'b1;
    {a_clear, a_wv1, a_wv2, a_acc1, a_acc2, a_start, a_ordy} = '0;
    {b_clear, b_wv1, b_wv2, b_acc1, b_acc2, b_start, b_ordy} = '0;
    a_ad1 = '0; a_ad2 = '0; a_d1 = '0; a_d2 = '0;
    b_ad1 = '0; b_ad2 = '0; b_d1 = '0; b_d2 = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    chk("rst_flat",     a_flat, 0);
    chk("rst_valid",    a_ovalid, 0);
    chk("rst_data",     a_odata, 0);
    chk("rst_last",     a_olast, 0);
    chk("rst_busy",     a_busy, 0);
    chk("rst_ovf",      a_ovf, 0);
    chk("rst_wr_ready", a_wr_ready, 1);

    a_write(1, 0, 32'd10, 0, 1, 1, 32'd20, 0);
    chk("ovr_lo", a_flat, {32'd0, 32'd0, 32'd20, 32'd10});
    a_write(1, 2, 32'd30, 0, 1, 3, 32'd40, 0);
    chk("ovr_all", a_flat, {32'd40, 32'd30, 32'd20, 32'd10});
    chk("ovr_ovf", a_ovf, 0);

    a_write(1, 2, 32'd5, 1, 1, 2, 32'd7, 1);
    chk("acc_acc", a_flat, {32'd40, 32'd42, 32'd20, 32'd10});
    a_write(1, 2, 32'd3, 1, 1, 2, 32'd9, 0);
    chk("acc_ovr", a_flat, {32'd40, 32'd9, 32'd20, 32'd10});
    a_write(1, 0, 32'd100, 0, 1, 0, 32'd23, 1);
    chk("ovr_acc", a_flat, {32'd40, 32'd9, 32'd20, 32'd123});
    chk("no_ovf_yet", a_ovf, 0);

    a_write(1, 1, 32'hFFFF_FFFF, 0, 0, 0, 32'd0, 0);
    a_write(1, 1, 32'd2, 1, 0, 0, 32'd0, 0);
    chk("wrap_val", a_flat, {32'd40, 32'd9, 32'd1, 32'd123});
    chk("wrap_ovf", a_ovf, 1);
    a_write(1, 3, 32'd5, 0, 0, 0, 32'd0, 0);
    chk("ovf_sticky", a_ovf, 1);
    chk("ovf_sticky_val", a_flat, {32'd5, 32'd9, 32'd1, 32'd123});

    a_clear = 1'b1;
    @(negedge clk);
    a_clear = 1'b0;
    chk("clear_flat", a_flat, 0);
    chk("clear_ovf", a_ovf, 0);

    a_write(1, 0, 32'd10, 0, 1, 1, 32'd20, 0);
    a_write(1, 2, 32'd30, 0, 1, 3, 32'd40, 0);
    chk("retile", a_flat, {32'd40, 32'd30, 32'd20, 32'd10});

    a_stream(16'b10_1101, 6, 1'b0);
    a_stream(16'b11_1100, 6, 1'b1);
    chk("busy_write_dropped", a_flat, {32'd40, 32'd30, 32'd20, 32'd10});

    // Clear in the second stream cycle aborts the stream.
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    a_ordy = 1'b1;
    chk("clr_s_first", a_odata, 32'd10);
    @(negedge clk);
    chk("clr_s_second", a_odata, 32'd20);
    a_clear = 1'b1;
    @(negedge clk);
    a_clear = 1'b0;
    a_ordy = 1'b0;
    chk("clr_s_busy",  a_busy, 0);
    chk("clr_s_valid", a_ovalid, 0);
    chk("clr_s_flat",  a_flat, 0);
    chk("clr_s_ready", a_wr_ready, 1);

    // DIM=3, WIDTH=16 with an out-of-range write alongside addr 8.
    for (int i = 0; i < 5; i++) begin
      if (2 * i + 1 <= 7) b_write(1, 2 * i, 16'(2 * i + 1), 1, 2 * i + 1, 16'(2 * i + 2));
      else                b_write(1, 2 * i, 16'(2 * i + 1), 1, 12, 16'h0077);
    end
    bexp = '0;
    for (int i = 0; i < 9; i++) bexp[i*16 +: 16] = 16'(i + 1);
    chk("b_flat", b_flat, bexp);
    chk("b_ovf", b_ovf, 0);

    sb = {};
    for (int i = 0; i < 9; i++) sb.push_back(32'(i + 1));
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    b_ordy = 1'b1;
    cyc = 0;
    while (sb.size() > 0 && cyc < 20) begin
      chk("b_valid", b_ovalid, 1);
      if (b_ovalid) begin
        chk("b_data", b_odata, sb[0][15:0]);
        chk("b_last", b_olast, (sb.size() == 1));
        void'(sb.pop_front());
      end
      @(negedge clk);
      cyc++;
    end
    b_ordy = 1'b0;
    chk("b_cycles", cyc, 9);
    chk("b_busy_after", b_busy, 0);
    chk("b_valid_after", b_ovalid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
